// File: rtl/imem_fetch_arbiter_pkg.sv
// rtl/imem_fetch_arbiter_pkg.sv - shared types and round-robin pick function for the fetch arbiter
package imem_arb_pkg;

  localparam int MAX_CORES  = 8;
  localparam int CORE_IDX_W = $clog2(MAX_CORES);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Scans n requesters starting at ptr and wrapping; returns a one-hot winner or zero.
  function automatic logic [MAX_CORES-1:0] rr_pick(
    input logic [MAX_CORES-1:0]  req,
    input logic [CORE_IDX_W-1:0] ptr,
    input int                    n
  );
    logic [MAX_CORES-1:0] win;
    logic                 found;
    int                   idx;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_CORES; i++) begin
      idx = (int'(ptr) + i) % n;
      if (i < n && !found && req[idx[CORE_IDX_W-1:0]]) begin
        win[idx[CORE_IDX_W-1:0]] = 1'b1;
        found                    = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/imem_fetch_arbiter_if.sv
// rtl/imem_fetch_arbiter_if.sv - fetch/memory bundle between cores, arbiter and shared imem
// Optional IMEM_ARB_PERF_EN adds the GntCount/ConflictCount counter outputs.
interface imem_fetch_arbiter_if #(
  parameter int NUM_CORES = 8,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic [NUM_CORES-1:0]        Req;
  logic [NUM_CORES*ADDR_W-1:0] Addr;
  logic [NUM_CORES-1:0]        Flush;
  logic [NUM_CORES-1:0]        Gnt;
  logic [NUM_CORES-1:0]        RdValid;
  logic [DATA_W-1:0]           RdData;
  logic [ADDR_W-1:0]           MemAddress;
  logic [DATA_W-1:0]           MemInstr;
  logic                        Busy;
`ifdef IMEM_ARB_PERF_EN
  logic [NUM_CORES*16-1:0]     GntCount;
  logic [15:0]                 ConflictCount;

  modport master (
    output Req, Addr, Flush, MemInstr,
    input  Gnt, RdValid, RdData, MemAddress, Busy, GntCount, ConflictCount
  );
  modport slave (
    input  Req, Addr, Flush, MemInstr,
    output Gnt, RdValid, RdData, MemAddress, Busy, GntCount, ConflictCount
  );
`else
  modport master (
    output Req, Addr, Flush, MemInstr,
    input  Gnt, RdValid, RdData, MemAddress, Busy
  );
  modport slave (
    input  Req, Addr, Flush, MemInstr,
    output Gnt, RdValid, RdData, MemAddress, Busy
  );
`endif
endinterface

// File: rtl/imem_fetch_arbiter_rr.sv
// rtl/imem_fetch_arbiter_rr.sv - combinational round-robin pick and pointer next-state
module rr_arbiter
  import imem_arb_pkg::*;
#(
  parameter int NUM_CORES = 8
) (
  input  logic [NUM_CORES-1:0]  req,
  input  logic [CORE_IDX_W-1:0] ptr,
  output logic [NUM_CORES-1:0]  gnt,
  output logic [CORE_IDX_W-1:0] winner,
  output logic [CORE_IDX_W-1:0] ptr_nxt
);

  logic [MAX_CORES-1:0] req_ext;
  logic [MAX_CORES-1:0] pick;

  always_comb begin
    req_ext                 = '0;
    req_ext[NUM_CORES-1:0]  = req;
    pick                    = rr_pick(req_ext, ptr, NUM_CORES);
    gnt                     = pick[NUM_CORES-1:0];
    winner                  = ptr;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (pick[i]) winner = CORE_IDX_W'(i);
    end
    // Pointer moves just past the winner; with no request it stays put.
    if (|req) begin
      ptr_nxt = (winner == CORE_IDX_W'(NUM_CORES - 1)) ? '0 : winner + CORE_IDX_W'(1);
    end else begin
      ptr_nxt = ptr;
    end
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// rtl/imem_fetch_arbiter.sv - round-robin sharing of one combinational imem among fetch ports
// Optional IMEM_ARB_PERF_EN adds per-core grant counters and a conflict counter.
module imem_fetch_arbiter
  import imem_arb_pkg::*;
#(
  parameter int NUM_CORES = 8,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  imem_fetch_arbiter_if.slave  bus
);

  logic [CORE_IDX_W-1:0] rr_ptr;
  logic [CORE_IDX_W-1:0] ptr_nxt;
  logic [CORE_IDX_W-1:0] winner;
  logic [NUM_CORES-1:0]  gnt_raw;
  logic [NUM_CORES-1:0]  gnt;
  logic [NUM_CORES-1:0]  rd_valid_q;
  logic [DATA_W-1:0]     rd_data_q;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  busy_q;
  state_t                state;

  rr_arbiter #(.NUM_CORES(NUM_CORES)) u_rr (
    .req     (bus.Req),
    .ptr     (rr_ptr),
    .gnt     (gnt_raw),
    .winner  (winner),
    .ptr_nxt (ptr_nxt)
  );

  // No grant may escape while the block is held in reset.
  assign gnt = Rst_n ? gnt_raw : '0;

  always_comb begin
    mem_addr = '0;
    if (|gnt) mem_addr = bus.Addr[int'(winner)*ADDR_W +: ADDR_W];
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rr_ptr     <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      rr_ptr     <= ptr_nxt;
      rd_valid_q <= gnt & ~bus.Flush;
      if (|gnt) rd_data_q <= bus.MemInstr;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.Req) begin
            state  <= ISSUE;
            busy_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (bus.Req == '0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Gnt        = gnt;
  assign bus.RdValid    = rd_valid_q;
  assign bus.RdData     = rd_data_q;
  assign bus.MemAddress = mem_addr;
  assign bus.Busy       = busy_q;

`ifdef IMEM_ARB_PERF_EN
  logic [15:0] gnt_cnt [NUM_CORES];
  logic [15:0] conflict_cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NUM_CORES; i++) gnt_cnt[i] <= '0;
      conflict_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (gnt[i] && gnt_cnt[i] != 16'hFFFF) gnt_cnt[i] <= gnt_cnt[i] + 16'd1;
      end
      if ($countones(bus.Req) > 1 && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_cnt_out
    assign bus.GntCount[g*16 +: 16] = gnt_cnt[g];
  end
  assign bus.ConflictCount = conflict_cnt;
`endif

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// tb/tb_imem_fetch_arbiter.sv - directed and randomized self-check of imem_fetch_arbiter against a reference model
module tb_imem_fetch_arbiter;

  localparam int N  = 8;
  localparam int AW = 32;
  localparam int DW = 32;

  logic Clk = 1'b0;
  logic Rst_n;
  int   checks = 0;
  int   errors = 0;

  imem_fetch_arbiter_if #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  imem_fetch_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Memory contents are a recognisable function of the word index.
  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'hC0DE_0000 | {18'b0, a[15:2]};
  endfunction

  assign bus.MemInstr = memword(bus.MemAddress);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the next requester at or after ptr in circular order.
  int          m_ptr;
  logic [7:0]  m_rv;
  logic [31:0] m_data;
  logic        m_busy;

  function automatic int winner_of(input logic [7:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge Clk or negedge Rst_n) begin
    int c;
    if (!Rst_n) begin
      m_ptr = 0; m_rv = 0; m_data = 0; m_busy = 0;
    end else begin
      c = winner_of(bus.Req, m_ptr);
      if (c >= 0) begin
        m_ptr  = (c + 1) % N;
        m_rv   = (8'(1) << c) & ~bus.Flush;
        m_data = memword(bus.Addr[c*AW +: AW]);
        m_busy = 1;
      end else begin
        m_rv   = 0;
        m_busy = 0;
      end
    end
  end

  always @(negedge Clk) begin
    int          c;
    logic [7:0]  eg;
    logic [31:0] ea;
    c  = Rst_n ? winner_of(bus.Req, m_ptr) : -1;
    eg = (c >= 0) ? (8'(1) << c) : 8'h00;
    ea = (c >= 0) ? bus.Addr[c*AW +: AW] : 32'h0;
    check("model_gnt", 32'(bus.Gnt), 32'(eg));
    check("model_memaddr", bus.MemAddress, ea);
    check("model_rdvalid", 32'(bus.RdValid), 32'(m_rv));
    check("model_rddata", bus.RdData, m_data);
    check("model_busy", 32'(bus.Busy), 32'(m_busy));
  end

  task automatic next();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst_n     = 1'b0;
    bus.Req   = 8'hFF;
    bus.Flush = 8'h00;
    for (int i = 0; i < N; i++) bus.Addr[i*AW +: AW] = 32'(i * 4 + 32'h100);

    // Reset holds everything quiet even with all requests up.
    next(); next();
    #3;
    check("rst_gnt", 32'(bus.Gnt), 32'h0);
    check("rst_rdvalid", 32'(bus.RdValid), 32'h0);
    check("rst_rddata", bus.RdData, 32'h0);
    check("rst_busy", 32'(bus.Busy), 32'h0);

    next();
    Rst_n = 1'b1;
    #3;
    check("first_gnt", 32'(bus.Gnt), 32'h01);

    // Full rotation with every core requesting.
    for (int k = 1; k <= 8; k++) begin
      next();
      #3;
      check("rot_gnt", 32'(bus.Gnt), 32'(8'(1) << (k % 8)));
      check("rot_rdvalid", 32'(bus.RdValid), 32'(8'(1) << (k - 1)));
    end

    // Single requester at address 0x10 reads word 4.
    next();
    bus.Req = 8'h08;
    bus.Addr[3*AW +: AW] = 32'h0000_0010;
    #3;
    check("solo_gnt", 32'(bus.Gnt), 32'h08);
    next();
    #3;
    check("solo_gnt2", 32'(bus.Gnt), 32'h08);
    check("solo_rdvalid", 32'(bus.RdValid), 32'h08);
    check("solo_rddata", bus.RdData, 32'hC0DE_0004);

    // Flush in the grant cycle kills the return but still advances the pointer.
    next();
    bus.Req   = 8'h20;
    bus.Flush = 8'h20;
    #3;
    check("flush_gnt", 32'(bus.Gnt), 32'h20);
    next();
    bus.Req   = 8'hFF;
    bus.Flush = 8'h00;
    #3;
    check("flush_rdvalid", 32'(bus.RdValid), 32'h00);
    check("flush_ptr_gnt", 32'(bus.Gnt), 32'h40);

    // Reset right after a grant drops the in-flight return.
    next();
    Rst_n   = 1'b0;
    bus.Req = 8'h00;
    #3;
    check("midrst_rdvalid", 32'(bus.RdValid), 32'h00);
    check("midrst_busy", 32'(bus.Busy), 32'h0);
    next();
    Rst_n = 1'b1;
    #3;
    check("midrst_rdvalid2", 32'(bus.RdValid), 32'h00);
    next();
    bus.Req = 8'hFF;
    #3;
    check("midrst_restart", 32'(bus.Gnt), 32'h01);

    // Randomized traffic with occasional flushes and resets.
    for (int t = 0; t < 600; t++) begin
      next();
      Rst_n     = ($urandom_range(0, 59) != 0);
      bus.Req   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      bus.Flush = 8'($urandom & $urandom & $urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) bus.Addr[i*AW +: AW] = $urandom;
      end
    end

`ifdef IMEM_ARB_PERF_EN
    next();
    Rst_n     = 1'b0;
    bus.Req   = 8'h00;
    bus.Flush = 8'h00;
    next();
    Rst_n   = 1'b1;
    bus.Req = 8'h03;
    for (int j = 1; j < 10; j++) next();
    next();
    bus.Req = 8'h00;
    #3;
    check("perf_gnt0", 32'(bus.GntCount[0 +: 16]), 32'd5);
    check("perf_gnt1", 32'(bus.GntCount[16 +: 16]), 32'd5);
    check("perf_conflict", 32'(bus.ConflictCount), 32'd10);
`endif

    next();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
